rot_right_pipe: RTL and testbench

- Pipelined 64-bit rotate-right unit with valid/ready handshake. It is the inverse of the combinational rotate-left stage used in the bash-S permutation path.
- Used by the inverse-permutation / self-check datapath: rot_right_pipe(rotate_left(x, r), r) == x.
- Six shift layers (32/16/8/4/2/1) split over three register stages. Accepts one beat per cycle at full throughput.

---
 rtl/rot_right_pipe.sv | 144 ++++++++++++++
 tb/tb_rot_right_pipe.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_right_pipe.sv
// Three-stage pipelined 64-bit rotate-right with valid/ready flow control.
// Each stage applies two binary rotate layers; stage 3 registers drive the outputs directly.
module rot_right_pipe #(
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [63:0]      data_i,
    input  logic [5:0]       rot_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [63:0]      data_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int NUM_STAGES = 3;

    // Stage registers. Each stage carries only the rotate bits it has not yet consumed.
    logic             s1_valid_reg, s1_valid_next;
    logic [63:0]      s1_data_reg,  s1_data_next;
    logic [3:0]       s1_rot_reg,   s1_rot_next;
    logic [TAG_W-1:0] s1_tag_reg,   s1_tag_next;

    logic             s2_valid_reg, s2_valid_next;
    logic [63:0]      s2_data_reg,  s2_data_next;
    logic [1:0]       s2_rot_reg,   s2_rot_next;
    logic [TAG_W-1:0] s2_tag_reg,   s2_tag_next;

    logic             s3_valid_reg, s3_valid_next;
    logic [63:0]      s3_data_reg,  s3_data_next;
    logic [TAG_W-1:0] s3_tag_reg,   s3_tag_next;

    logic s1_load;
    logic s2_load;
    logic s3_load;

    // Rotate network: stage gi consumes rot bits [5-2*gi : 4-2*gi].
    logic [63:0] stage_in  [NUM_STAGES];
    logic [63:0] stage_out [NUM_STAGES];
    logic [1:0]  stage_rot [NUM_STAGES];

    assign stage_in[0]  = data_i;
    assign stage_in[1]  = s1_data_reg;
    assign stage_in[2]  = s2_data_reg;
    assign stage_rot[0] = rot_i[5:4];
    assign stage_rot[1] = s1_rot_reg[3:2];
    assign stage_rot[2] = s2_rot_reg[1:0];

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage_rot
            localparam int HI_SH = 32 >> (2 * gi);
            localparam int LO_SH = HI_SH / 2;
            logic [63:0] mid;
            logic [63:0] din;

            assign din = stage_in[gi];
            assign mid = stage_rot[gi][1] ? {din[HI_SH-1:0], din[63:HI_SH]} : din;
            assign stage_out[gi] = stage_rot[gi][0] ? {mid[LO_SH-1:0], mid[63:LO_SH]} : mid;
        end
    endgenerate

    // An empty stage is always loadable, so bubbles collapse and ready ripples back combinationally.
    assign s3_load = !s3_valid_reg || ready_i;
    assign s2_load = !s2_valid_reg || s3_load;
    assign s1_load = !s1_valid_reg || s2_load;
    assign ready_o = s1_load;

    always_comb begin
        s1_valid_next = s1_valid_reg;
        s1_data_next  = s1_data_reg;
        s1_rot_next   = s1_rot_reg;
        s1_tag_next   = s1_tag_reg;
        s2_valid_next = s2_valid_reg;
        s2_data_next  = s2_data_reg;
        s2_rot_next   = s2_rot_reg;
        s2_tag_next   = s2_tag_reg;
        s3_valid_next = s3_valid_reg;
        s3_data_next  = s3_data_reg;
        s3_tag_next   = s3_tag_reg;

        if (s1_load) begin
            s1_valid_next = valid_i;
            // Payload is captured only on an accepted beat; bubbles leave it untouched.
            if (valid_i) begin
                s1_data_next = stage_out[0];
                s1_rot_next  = rot_i[3:0];
                s1_tag_next  = tag_i;
            end
        end

        if (s2_load) begin
            s2_valid_next = s1_valid_reg;
            if (s1_valid_reg) begin
                s2_data_next = stage_out[1];
                s2_rot_next  = s1_rot_reg[1:0];
                s2_tag_next  = s1_tag_reg;
            end
        end

        if (s3_load) begin
            s3_valid_next = s2_valid_reg;
            if (s2_valid_reg) begin
                s3_data_next = stage_out[2];
                s3_tag_next  = s2_tag_reg;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_rot_reg   <= '0;
            s1_tag_reg   <= '0;
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
            s2_rot_reg   <= '0;
            s2_tag_reg   <= '0;
            s3_valid_reg <= 1'b0;
            s3_data_reg  <= '0;
            s3_tag_reg   <= '0;
        end else begin
            s1_valid_reg <= s1_valid_next;
            s1_data_reg  <= s1_data_next;
            s1_rot_reg   <= s1_rot_next;
            s1_tag_reg   <= s1_tag_next;
            s2_valid_reg <= s2_valid_next;
            s2_data_reg  <= s2_data_next;
            s2_rot_reg   <= s2_rot_next;
            s2_tag_reg   <= s2_tag_next;
            s3_valid_reg <= s3_valid_next;
            s3_data_reg  <= s3_data_next;
            s3_tag_reg   <= s3_tag_next;
        end
    end

    assign valid_o = s3_valid_reg;
    assign data_o  = s3_data_reg;
    assign tag_o   = s3_tag_reg;

endmodule

// File: tb/tb_rot_right_pipe.sv
// Self-checking bench for rot_right_pipe: directed vectors, flow control, reset and a
// randomized round trip checked against plain-arithmetic rotate models.
module tb_rot_right_pipe;

    localparam int TAG_W = 4;

    logic             clk_i;
    logic             rst_i;
    logic             valid_i;
    logic             ready_o;
    logic [63:0]      data_i;
    logic [5:0]       rot_i;
    logic [TAG_W-1:0] tag_i;
    logic             valid_o;
    logic             ready_i;
    logic [63:0]      data_o;
    logic [TAG_W-1:0] tag_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [63:0]      data;
        logic [5:0]       rot;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } beat_t;

    beat_t in_q[$];
    beat_t out_q[$];

    rot_right_pipe #(.TAG_W(TAG_W)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .rot_i   (rot_i),
        .tag_i   (tag_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .tag_o   (tag_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    // Inputs change only just after the rising edge, so the falling edge sees what the next edge will see.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (valid_i && ready_o) in_q.push_back('{data_i, rot_i, tag_i, cyc});
            if (valid_o && ready_i) out_q.push_back('{data_o, 6'd0, tag_o, cyc});
        end
    end

    function automatic logic [63:0] rotr_ref(input logic [63:0] x, input logic [5:0] r);
        if (r == 6'd0) return x;
        return (x >> r) | (x << (64 - int'(r)));
    endfunction

    function automatic logic [63:0] rotl_ref(input logic [63:0] x, input logic [5:0] r);
        if (r == 6'd0) return x;
        return (x << r) | (x >> (64 - int'(r)));
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        data_i = '0; rot_i = '0; tag_i = '0;
        repeat (2) tick();
        rst_i = 1'b0;
        tick();
        ready_i = 1'b0; valid_i = 1'b1;
        data_i = 64'hDEAD_BEEF_CAFE_F00D; rot_i = 6'd5; tag_i = 4'd3;
        tick();
        tag_i = 4'd4;
        tick();
        valid_i = 1'b0;
        tick();
        #2;
        checks++;
        if (valid_o !== 1'b1) begin
            failures++; $display("FAIL reset_preload: valid_o=%b expected 1", valid_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: valid_o=%b expected 0", valid_o); end
        checks++;
        if (data_o !== 64'd0) begin failures++; $display("FAIL reset_data: data_o=%h expected 0", data_o); end
        checks++;
        if (tag_o !== '0) begin failures++; $display("FAIL reset_tag: tag_o=%h expected 0", tag_o); end
        checks++;
        if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: ready_o=%b expected 1", ready_o); end
        repeat (2) tick();
        rst_i = 1'b0; ready_i = 1'b1;
        in_q.delete(); out_q.delete();
        repeat (6) tick();
        checks++;
        if (out_q.size() != 0) begin
            failures++; $display("FAIL reset_no_beats: beats=%0d expected 0", out_q.size());
        end
        $display("reset: valid_o=%b ready_o=%b beats_after_release=%0d", valid_o, ready_o, out_q.size());
    endtask

    task automatic test_single();
        logic [63:0] din [5];
        logic [5:0]  rv  [5];
        logic [63:0] exp_d [5];
        din   = '{64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF,
                  64'h0123456789ABCDEF, 64'h1};
        rv    = '{6'd0, 6'd4, 6'd32, 6'd63, 6'd1};
        exp_d = '{64'h0123456789ABCDEF, 64'hF0123456789ABCDE, 64'h89ABCDEF01234567,
                  64'h02468ACF13579BDE, 64'h8000000000000000};
        for (int i = 0; i < 5; i++) begin
            in_q.delete(); out_q.delete();
            ready_i = 1'b1; valid_i = 1'b1;
            data_i = din[i]; rot_i = rv[i]; tag_i = TAG_W'(i + 1);
            tick();
            valid_i = 1'b0;
            repeat (6) tick();
            checks++;
            if (out_q.size() != 1 || in_q.size() != 1) begin
                failures++;
                $display("FAIL single_count rot=%0d: out=%0d in=%0d expected 1", rv[i], out_q.size(), in_q.size());
            end else begin
                checks++;
                if (out_q[0].data !== exp_d[i]) begin
                    failures++;
                    $display("FAIL single_data rot=%0d: got %h expected %h", rv[i], out_q[0].data, exp_d[i]);
                end
                checks++;
                if (out_q[0].tag !== TAG_W'(i + 1)) begin
                    failures++;
                    $display("FAIL single_tag rot=%0d: got %h expected %h", rv[i], out_q[0].tag, TAG_W'(i + 1));
                end
                checks++;
                if (out_q[0].cyc - in_q[0].cyc != 3) begin
                    failures++;
                    $display("FAIL single_latency rot=%0d: got %0d expected 3", rv[i], out_q[0].cyc - in_q[0].cyc);
                end
                $display("single: rot=%0d tag=%0h data_o=%h", rv[i], out_q[0].tag, out_q[0].data);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] dv [16];
        in_q.delete(); out_q.delete();
        ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dv[i] = {$urandom, $urandom};
            valid_i = 1'b1; data_i = dv[i]; rot_i = 6'(i * 4); tag_i = TAG_W'(i);
            tick();
        end
        valid_i = 1'b0;
        repeat (6) tick();
        checks++;
        if (out_q.size() != 16 || in_q.size() != 16) begin
            failures++;
            $display("FAIL stream_count: out=%0d in=%0d expected 16", out_q.size(), in_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (out_q[i].data !== rotr_ref(dv[i], 6'(i * 4)) || out_q[i].tag !== TAG_W'(i)
                    || out_q[i].cyc != out_q[0].cyc + i) begin
                    failures++;
                    $display("FAIL stream_beat%0d: got %h tag %h cyc+%0d expected %h tag %h cyc+%0d",
                             i, out_q[i].data, out_q[i].tag, out_q[i].cyc - out_q[0].cyc,
                             rotr_ref(dv[i], 6'(i * 4)), TAG_W'(i), i);
                end
                $display("stream: tag=%0h data_o=%h", out_q[i].tag, out_q[i].data);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] dv [5];
        logic [5:0]  rv [5];
        int          k;
        logic        held;
        logic [63:0] hd;
        logic [TAG_W-1:0] ht;
        logic        last_ready;
        in_q.delete(); out_q.delete();
        for (int i = 0; i < 5; i++) begin
            dv[i] = {$urandom, $urandom};
            rv[i] = 6'($urandom_range(0, 63));
        end
        k = 0; held = 1'b0; hd = '0; ht = '0; last_ready = 1'b1;
        ready_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            valid_i = (k < 5);
            if (k < 5) begin data_i = dv[k]; rot_i = rv[k]; tag_i = TAG_W'(k + 8); end
            #2;
            last_ready = ready_o;
            if (valid_o) begin
                if (!held) begin
                    held = 1'b1; hd = data_o; ht = tag_o;
                end else begin
                    checks++;
                    if (data_o !== hd || tag_o !== ht) begin
                        failures++;
                        $display("FAIL bp_stable: got %h/%h expected %h/%h", data_o, tag_o, hd, ht);
                    end
                end
            end
            if (valid_i && ready_o) begin
                tick(); k++;
            end else begin
                tick();
            end
        end
        checks++;
        if (k != 3) begin failures++; $display("FAIL bp_accepts: got %0d expected 3", k); end
        checks++;
        if (last_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low: ready_o=%b expected 0", last_ready); end
        for (int c = 0; c < 20; c++) begin
            ready_i = 1'b1;
            valid_i = (k < 5);
            if (k < 5) begin data_i = dv[k]; rot_i = rv[k]; tag_i = TAG_W'(k + 8); end
            #2;
            if (c == 0) begin
                checks++;
                if (ready_o !== 1'b1) begin
                    failures++; $display("FAIL bp_ready_rise: ready_o=%b expected 1", ready_o);
                end
            end
            if (valid_i && ready_o) begin
                tick(); k++;
            end else begin
                tick();
            end
            if (k == 5 && out_q.size() == 5) break;
        end
        valid_i = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_q.size() != 5) begin
            failures++; $display("FAIL bp_count: got %0d expected 5", out_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (out_q[i].data !== rotr_ref(dv[i], rv[i]) || out_q[i].tag !== TAG_W'(i + 8)) begin
                    failures++;
                    $display("FAIL bp_beat%0d: got %h tag %h expected %h tag %h", i, out_q[i].data,
                             out_q[i].tag, rotr_ref(dv[i], rv[i]), TAG_W'(i + 8));
                end
                $display("backpressure: rot=%0d tag=%0h data_o=%h", rv[i], out_q[i].tag, out_q[i].data);
            end
        end
    endtask

    task automatic test_reset_midstream();
        in_q.delete(); out_q.delete();
        ready_i = 1'b1;
        valid_i = 1'b1; data_i = {$urandom, $urandom}; rot_i = 6'd3; tag_i = 4'd1;
        tick();
        data_i = {$urandom, $urandom}; rot_i = 6'd9; tag_i = 4'd2;
        tick();
        valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        in_q.delete(); out_q.delete();
        checks++;
        if (valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid: valid_o=%b expected 0", valid_o); end
        valid_i = 1'b1; data_i = 64'hFF; rot_i = 6'd8; tag_i = 4'd7;
        tick();
        valid_i = 1'b0;
        repeat (8) tick();
        checks++;
        if (out_q.size() != 1) begin
            failures++; $display("FAIL midrst_count: got %0d expected 1", out_q.size());
        end else begin
            checks++;
            if (out_q[0].data !== 64'hFF00000000000000 || out_q[0].tag !== 4'd7) begin
                failures++;
                $display("FAIL midrst_beat: got %h tag %h expected ff00000000000000 tag 7",
                         out_q[0].data, out_q[0].tag);
            end
            $display("reset_midstream: tag=%0h data_o=%h", out_q[0].tag, out_q[0].data);
        end
    endtask

    task automatic test_round_trip();
        localparam int N = 10000;
        int          sent, got, guard;
        logic        acc, hold_pending;
        logic [63:0] hd;
        logic [TAG_W-1:0] ht;
        logic [63:0] cur_d;
        logic [5:0]  cur_r;
        beat_t       o, e;
        in_q.delete(); out_q.delete();
        sent = 0; got = 0; guard = 0; hold_pending = 1'b0; hd = '0; ht = '0;
        cur_d = {$urandom, $urandom}; cur_r = 6'($urandom_range(0, 63));
        while (got < N && guard < 60000) begin
            valid_i = (sent < N) && ($urandom_range(0, 3) != 0);
            data_i = cur_d; rot_i = cur_r; tag_i = TAG_W'(sent);
            ready_i = ($urandom_range(0, 3) != 0);
            #2;
            if (hold_pending) begin
                checks++;
                if (valid_o !== 1'b1 || data_o !== hd || tag_o !== ht) begin
                    failures++;
                    $display("FAIL rt_hold: got v=%b %h/%h expected v=1 %h/%h", valid_o, data_o, tag_o, hd, ht);
                end
            end
            acc = valid_i && ready_o;
            hold_pending = valid_o && !ready_i;
            hd = data_o; ht = tag_o;
            tick();
            if (acc) begin
                sent++;
                cur_d = {$urandom, $urandom}; cur_r = 6'($urandom_range(0, 63));
            end
            while (out_q.size() > 0) begin
                o = out_q.pop_front();
                checks++;
                if (in_q.size() == 0) begin
                    failures++;
                    $display("FAIL rt_extra: unexpected beat %h tag %h", o.data, o.tag);
                end else begin
                    e = in_q.pop_front();
                    if (rotl_ref(o.data, e.rot) !== e.data || o.tag !== e.tag) begin
                        failures++;
                        $display("FAIL rt_beat%0d: rotl(%h,%0d)=%h tag %h expected %h tag %h", got, o.data,
                                 e.rot, rotl_ref(o.data, e.rot), o.tag, e.data, e.tag);
                    end
                end
                $display("round_trip: n=%0d tag=%0h data_o=%h", got, o.tag, o.data);
                got++;
            end
            guard++;
        end
        valid_i = 1'b0;
        checks++;
        if (got != N) begin failures++; $display("FAIL rt_count: got %0d expected %0d", got, N); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_round_trip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
